// File: rtl/cache_axi_pkg.sv
// Shared encodings for the cache-to-AXI adapter: request types, FSM states,
// fixed AXI attributes and the address-channel decode helper.
package cache_axi_pkg;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_ID     = 4'h0;
  localparam logic       AXI_LOCK   = 1'b0;
  localparam logic [3:0] AXI_CACHE  = 4'h0;
  localparam logic [2:0] AXI_PROT   = 3'h0;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} wr_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ax_req_t;

  // Lines are 4 x 32-bit INCR beats from the aligned base; singles are one beat.
  function automatic ax_req_t ax_decode(input logic [2:0] typ, input logic [31:0] addr);
    ax_req_t r;
    if (typ == TYPE_LINE) begin
      r.addr = {addr[31:4], 4'h0};
      r.len  = 8'd3;
      r.size = 3'd2;
    end else begin
      r.addr = addr;
      r.len  = 8'd0;
      r.size = {1'b0, typ[1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/wr_beat_serializer.sv
// Splits a captured 128-bit line into 32-bit W beats, low word first.
module wr_beat_serializer
  import cache_axi_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         load_i,
  input  logic [127:0] line_i,
  input  logic [1:0]   last_beat_i,
  input  logic         wvalid_i,
  input  logic         wready_i,
  output logic [31:0]  wdata_o,
  output logic         wlast_o
);

  logic [127:0] data_q;
  logic [1:0]   cnt_q;
  logic [1:0]   last_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else if (load_i) begin
      data_q <= line_i;
      cnt_q  <= '0;
      last_q <= last_beat_i;
    end else if (wvalid_i && wready_i) begin
      data_q <= {32'h0, data_q[127:32]};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign wdata_o = data_q[31:0];
  assign wlast_o = (cnt_q == last_q);

endmodule

// File: rtl/cache_axi_adapter.sv
// Bridges the cache refill/writeback port onto AXI4 with one read and one
// write in flight; a pending or active write always blocks new reads.
module cache_axi_adapter
  import cache_axi_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req_i,
  input  logic [2:0]   rd_type_i,
  input  logic [31:0]  rd_addr_i,
  output logic         rd_rdy_o,
  output logic         ret_valid_o,
  output logic         ret_last_o,
  output logic [31:0]  ret_data_o,
  input  logic         wr_req_i,
  input  logic [2:0]   wr_type_i,
  input  logic [31:0]  wr_addr_i,
  input  logic [3:0]   wr_wstrb_i,
  input  logic [127:0] wr_data_i,
  output logic         wr_rdy_o,
  output logic [31:0]  araddr_o,
  output logic [7:0]   arlen_o,
  output logic [2:0]   arsize_o,
  output logic         arvalid_o,
  input  logic         arready_i,
  input  logic [31:0]  rdata_i,
  input  logic [1:0]   rresp_i,
  input  logic         rlast_i,
  input  logic         rvalid_i,
  output logic         rready_o,
  output logic [31:0]  awaddr_o,
  output logic [7:0]   awlen_o,
  output logic [2:0]   awsize_o,
  output logic         awvalid_o,
  input  logic         awready_i,
  output logic [31:0]  wdata_o,
  output logic [3:0]   wstrb_o,
  output logic         wlast_o,
  output logic         wvalid_o,
  input  logic         wready_i,
  input  logic [1:0]   bresp_i,
  input  logic         bvalid_i,
  output logic         bready_o
);

  rd_state_e r_state_q, r_state_d;
  wr_state_e w_state_q, w_state_d;
  ax_req_t   ar_q, aw_q, aw_d;
  logic [3:0] wstrb_q;
  logic rd_acc, wr_acc;
  logic unused_resp;

  // Error responses are deliberately dropped; data passes through regardless.
  assign unused_resp = ^{rresp_i, bresp_i};

  assign rd_rdy_o = (r_state_q == R_IDLE) && (w_state_q == W_IDLE) && !wr_req_i;
  assign rd_acc   = rd_req_i && rd_rdy_o;
  assign wr_acc   = wr_req_i && wr_rdy_o;
  assign aw_d     = ax_decode(wr_type_i, wr_addr_i);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      ar_q      <= '0;
      aw_q      <= '0;
      wstrb_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      if (rd_acc) ar_q <= ax_decode(rd_type_i, rd_addr_i);
      if (wr_acc) begin
        aw_q    <= aw_d;
        wstrb_q <= (wr_type_i == TYPE_LINE) ? 4'hf : wr_wstrb_i;
      end
    end
  end

  always_comb begin
    r_state_d   = r_state_q;
    arvalid_o   = 1'b0;
    rready_o    = 1'b0;
    ret_valid_o = 1'b0;
    ret_last_o  = 1'b0;
    case (r_state_q)
      R_IDLE: if (rd_acc) r_state_d = R_AR;
      R_AR: begin
        arvalid_o = 1'b1;
        if (arready_i) r_state_d = R_DATA;
      end
      R_DATA: begin
        rready_o    = 1'b1;
        ret_valid_o = rvalid_i;
        ret_last_o  = rvalid_i && rlast_i;
        if (rvalid_i && rlast_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    wr_rdy_o  = 1'b0;
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    bready_o  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        wr_rdy_o = 1'b1;
        if (wr_req_i) w_state_d = W_AW;
      end
      W_AW: begin
        awvalid_o = 1'b1;
        if (awready_i) w_state_d = W_DATA;
      end
      W_DATA: begin
        wvalid_o = 1'b1;
        if (wready_i && wlast_o) w_state_d = W_B;
      end
      W_B: begin
        bready_o = 1'b1;
        if (bvalid_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign ret_data_o = rdata_i;
  assign araddr_o   = ar_q.addr;
  assign arlen_o    = ar_q.len;
  assign arsize_o   = ar_q.size;
  assign awaddr_o   = aw_q.addr;
  assign awlen_o    = aw_q.len;
  assign awsize_o   = aw_q.size;
  assign wstrb_o    = wstrb_q;

  wr_beat_serializer u_ser (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (wr_acc),
    .line_i     (wr_data_i),
    .last_beat_i(aw_d.len[1:0]),
    .wvalid_i   (wvalid_o),
    .wready_i   (wready_i),
    .wdata_o    (wdata_o),
    .wlast_o    (wlast_o)
  );

endmodule

// File: tb/tb_cache_axi_adapter.sv
// Directed bench: stimulus queues expected AXI/return traffic, a negedge
// monitor pops and compares on every handshake and on queued level checks.
module tb_cache_axi_adapter;
  import cache_axi_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic rd_req, rd_rdy, ret_valid, ret_last, wr_req, wr_rdy;
  logic [2:0] rd_type, wr_type;
  logic [31:0] rd_addr, wr_addr, ret_data;
  logic [3:0] wr_wstrb;
  logic [127:0] wr_data;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [1:0] rresp, bresp;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready;

  cache_axi_adapter dut (
    .clk(clk), .resetn(resetn),
    .rd_req_i(rd_req), .rd_type_i(rd_type), .rd_addr_i(rd_addr), .rd_rdy_o(rd_rdy),
    .ret_valid_o(ret_valid), .ret_last_o(ret_last), .ret_data_o(ret_data),
    .wr_req_i(wr_req), .wr_type_i(wr_type), .wr_addr_i(wr_addr), .wr_wstrb_i(wr_wstrb),
    .wr_data_i(wr_data), .wr_rdy_o(wr_rdy),
    .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize), .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready),
    .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
  );

  // Slave model: ready after a configurable stall, R data = {D0+beat, araddr[23:0]}.
  int ar_stall, aw_stall, w_stall, r_gap, b_delay;
  int ar_cnt, aw_cnt, w_cnt, b_cnt, r_wait;
  logic r_pend, b_pend;
  logic [31:0] r_addr;
  logic [7:0] r_len, r_beat;

  assign arready = arvalid && (ar_cnt >= ar_stall);
  assign awready = awvalid && (aw_cnt >= aw_stall);
  assign wready  = wvalid && (w_cnt >= w_stall);
  assign rvalid  = r_pend && (r_wait == 0);
  assign rdata   = {8'hD0 + r_beat, r_addr[23:0]};
  assign rlast   = rvalid && (r_beat == r_len);
  assign rresp   = r_beat[0] ? 2'b10 : 2'b00;
  assign bvalid  = b_pend && (b_cnt >= b_delay);
  assign bresp   = 2'b10;

  always @(posedge clk) begin
    if (!resetn) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; r_wait <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0; r_addr <= '0; r_len <= '0; r_beat <= '0;
    end else begin
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (arvalid && arready) begin
        r_pend <= 1'b1; r_addr <= araddr; r_len <= arlen; r_beat <= '0; r_wait <= r_gap;
      end else if (r_pend) begin
        if (r_wait > 0) r_wait <= r_wait - 1;
        else if (rready) begin
          r_beat <= r_beat + 8'd1;
          if (r_beat == r_len) r_pend <= 1'b0;
        end
      end
      if (wvalid && wready && wlast) begin
        b_pend <= 1'b1; b_cnt <= 0;
      end else if (b_pend) begin
        if (bvalid && bready) b_pend <= 1'b0;
        else b_cnt <= b_cnt + 1;
      end
    end
  end

  typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [2:0] size;} ax_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} w_t;
  typedef struct packed {logic [31:0] data; logic last;} ret_t;
  typedef struct {int id; logic [31:0] exp; string name;} lchk_t;

  ax_t exp_ar[$], exp_aw[$];
  w_t exp_w[$];
  ret_t exp_ret[$];
  lchk_t lq[$];

  localparam int S_RD_RDY = 0, S_WR_RDY = 1, S_ARVALID = 2, S_AWVALID = 3, S_WVALID = 4,
                 S_RREADY = 5, S_BREADY = 6, S_RET_VALID = 7, S_RET_LAST = 8,
                 S_ARADDR = 9, S_ARLEN = 10, S_AWADDR = 11, S_AWLEN = 12;

  function automatic logic [31:0] sig_val(int id);
    case (id)
      S_RD_RDY:    return {31'b0, rd_rdy};
      S_WR_RDY:    return {31'b0, wr_rdy};
      S_ARVALID:   return {31'b0, arvalid};
      S_AWVALID:   return {31'b0, awvalid};
      S_WVALID:    return {31'b0, wvalid};
      S_RREADY:    return {31'b0, rready};
      S_BREADY:    return {31'b0, bready};
      S_RET_VALID: return {31'b0, ret_valid};
      S_RET_LAST:  return {31'b0, ret_last};
      S_ARADDR:    return araddr;
      S_ARLEN:     return {24'b0, arlen};
      S_AWADDR:    return awaddr;
      S_AWLEN:     return {24'b0, awlen};
      default:     return 32'hDEAD_BEEF;
    endcase
  endfunction

  logic mon_en, done;
  int checks, errors, cyc;
  logic ar_hold, aw_hold, w_hold;
  ax_t ar_prev, aw_prev;
  w_t w_prev;

  task automatic chk(input int id, input logic [31:0] exp, input string name);
    lq.push_back('{id: id, exp: exp, name: name});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_for(input int id, input logic [31:0] v, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (sig_val(id) == v) break;
      tick();
    end
    chk(id, v, name);
  endtask

  // Monitor / scoreboard
  initial begin
    lchk_t c;
    ax_t ea;
    w_t ew;
    ret_t er;
    checks = 0; errors = 0; cyc = 0;
    ar_hold = 1'b0; aw_hold = 1'b0; w_hold = 1'b0;
    ar_prev = '0; aw_prev = '0; w_prev = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cyc++;
        while (lq.size() > 0) begin
          c = lq.pop_front();
          checks++;
          if (sig_val(c.id) !== c.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", c.name, sig_val(c.id), c.exp);
          end
        end
        if (arvalid && arready) begin
          checks++;
          if (exp_ar.size() == 0) begin
            errors++; $display("FAIL ar_unexpected: got %h/%0d/%0d expected none", araddr, arlen, arsize);
          end else begin
            ea = exp_ar.pop_front();
            if ({araddr, arlen, arsize} !== ea) begin
              errors++; $display("FAIL ar_payload: got %h/%0d/%0d expected %h/%0d/%0d",
                                 araddr, arlen, arsize, ea.addr, ea.len, ea.size);
            end
          end
        end
        if (awvalid && awready) begin
          checks++;
          if (exp_aw.size() == 0) begin
            errors++; $display("FAIL aw_unexpected: got %h/%0d/%0d expected none", awaddr, awlen, awsize);
          end else begin
            ea = exp_aw.pop_front();
            if ({awaddr, awlen, awsize} !== ea) begin
              errors++; $display("FAIL aw_payload: got %h/%0d/%0d expected %h/%0d/%0d",
                                 awaddr, awlen, awsize, ea.addr, ea.len, ea.size);
            end
          end
        end
        if (wvalid && wready) begin
          checks++;
          if (exp_w.size() == 0) begin
            errors++; $display("FAIL w_unexpected: got %h/%h/%b expected none", wdata, wstrb, wlast);
          end else begin
            ew = exp_w.pop_front();
            if ({wdata, wstrb, wlast} !== ew) begin
              errors++; $display("FAIL w_beat: got %h/%h/%b expected %h/%h/%b",
                                 wdata, wstrb, wlast, ew.data, ew.strb, ew.last);
            end
          end
        end
        if (ret_valid) begin
          checks++;
          if (exp_ret.size() == 0) begin
            errors++; $display("FAIL ret_unexpected: got %h/%b expected none", ret_data, ret_last);
          end else begin
            er = exp_ret.pop_front();
            if ({ret_data, ret_last} !== er) begin
              errors++; $display("FAIL ret_beat: got %h/%b expected %h/%b", ret_data, ret_last, er.data, er.last);
            end
          end
        end
        checks++;
        if (ret_valid !== rvalid || (rvalid && !rready)) begin
          errors++; $display("FAIL ret_follows_r: got ret_valid=%b rready=%b expected both=%b", ret_valid, rready, rvalid);
        end
        if (ar_hold) begin
          checks++;
          if (!arvalid || {araddr, arlen, arsize} !== ar_prev) begin
            errors++; $display("FAIL ar_stable: got %b/%h expected 1/%h", arvalid, araddr, ar_prev.addr);
          end
        end
        if (aw_hold) begin
          checks++;
          if (!awvalid || {awaddr, awlen, awsize} !== aw_prev) begin
            errors++; $display("FAIL aw_stable: got %b/%h expected 1/%h", awvalid, awaddr, aw_prev.addr);
          end
        end
        if (w_hold) begin
          checks++;
          if (!wvalid || {wdata, wstrb, wlast} !== w_prev) begin
            errors++; $display("FAIL w_stable: got %b/%h expected 1/%h", wvalid, wdata, w_prev.data);
          end
        end
        ar_hold = resetn && arvalid && !arready; ar_prev = {araddr, arlen, arsize};
        aw_hold = resetn && awvalid && !awready; aw_prev = {awaddr, awlen, awsize};
        w_hold  = resetn && wvalid && !wready;   w_prev  = {wdata, wstrb, wlast};
        if (cyc > 4000) begin
          errors++;
          $display("FAIL watchdog: got %0d cycles expected completion before 4000", cyc);
          $display("Simulation finished: %0d checks, %0d errors", checks, errors);
          $fatal(1, "watchdog expired");
        end
        if (done) begin
          checks += 4;
          if (exp_ar.size() != 0) begin errors++; $display("FAIL ar_left: got %0d expected 0", exp_ar.size()); end
          if (exp_aw.size() != 0) begin errors++; $display("FAIL aw_left: got %0d expected 0", exp_aw.size()); end
          if (exp_w.size() != 0) begin errors++; $display("FAIL w_left: got %0d expected 0", exp_w.size()); end
          if (exp_ret.size() != 0) begin errors++; $display("FAIL ret_left: got %0d expected 0", exp_ret.size()); end
          $display("Simulation finished: %0d checks, %0d errors", checks, errors);
          $finish;
        end
      end
    end
  end

  // Stimulus
  initial begin
    rd_req = 0; rd_type = '0; rd_addr = '0; wr_req = 0; wr_type = '0; wr_addr = '0;
    wr_wstrb = '0; wr_data = '0; ar_stall = 0; aw_stall = 0; w_stall = 0; r_gap = 0; b_delay = 0;
    resetn = 0; mon_en = 0; done = 0;
    repeat (3) tick();
    resetn = 1; mon_en = 1;
    chk(S_RD_RDY, 1, "rst_rd_rdy");   chk(S_WR_RDY, 1, "rst_wr_rdy");
    chk(S_ARVALID, 0, "rst_arvalid"); chk(S_AWVALID, 0, "rst_awvalid");
    chk(S_WVALID, 0, "rst_wvalid");   chk(S_RREADY, 0, "rst_rready");
    chk(S_BREADY, 0, "rst_bready");   chk(S_RET_VALID, 0, "rst_ret_valid");
    chk(S_ARADDR, 0, "rst_araddr");   chk(S_ARLEN, 0, "rst_arlen");
    chk(S_AWADDR, 0, "rst_awaddr");   chk(S_AWLEN, 0, "rst_awlen");
    tick();

    // Line read, 2-cycle gap before R
    r_gap = 2;
    exp_ar.push_back('{32'h1234_5670, 8'd3, 3'd2});
    exp_ret.push_back('{32'hD034_5670, 1'b0}); exp_ret.push_back('{32'hD134_5670, 1'b0});
    exp_ret.push_back('{32'hD234_5670, 1'b0}); exp_ret.push_back('{32'hD334_5670, 1'b1});
    rd_req = 1; rd_type = TYPE_LINE; rd_addr = 32'h1234_5678;
    chk(S_RD_RDY, 1, "rd_line_rdy");
    tick(); rd_req = 0;
    chk(S_ARVALID, 1, "rd_line_arvalid"); chk(S_ARADDR, 32'h1234_5670, "rd_line_araddr");
    wait_for(S_RET_LAST, 1, 20, "rd_line_last");
    chk(S_RD_RDY, 0, "rd_line_busy");
    tick(); chk(S_RD_RDY, 1, "rd_line_rdy_after");
    tick();

    // Line write, zero-wait slave: 7 cycles accept to wr_rdy
    exp_aw.push_back('{32'h0000_A000, 8'd3, 3'd2});
    exp_w.push_back('{32'h1111_1111, 4'hf, 1'b0}); exp_w.push_back('{32'h2222_2222, 4'hf, 1'b0});
    exp_w.push_back('{32'h3333_3333, 4'hf, 1'b0}); exp_w.push_back('{32'h4444_4444, 4'hf, 1'b1});
    wr_req = 1; wr_type = TYPE_LINE; wr_addr = 32'h0000_A00C; wr_wstrb = 4'h0;
    wr_data = 128'h44444444_33333333_22222222_11111111;
    chk(S_WR_RDY, 1, "wr_line_rdy");
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        wr_req = 0;
        chk(S_AWVALID, 1, "wr_line_awvalid"); chk(S_WVALID, 0, "wr_line_wvalid_early");
      end
      if (k == 2) chk(S_WVALID, 1, "wr_line_wvalid");
      chk(S_WR_RDY, 0, "wr_line_busy");
    end
    tick(); chk(S_WR_RDY, 1, "wr_line_rdy_after");
    tick();

    // Single word write with partial strobe
    exp_aw.push_back('{32'h0000_2004, 8'd0, 3'd2});
    exp_w.push_back('{32'hCAFE_BABE, 4'b0111, 1'b1});
    wr_req = 1; wr_type = TYPE_WORD; wr_addr = 32'h0000_2004; wr_wstrb = 4'b0111;
    wr_data = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CAFEBABE;
    tick(); wr_req = 0;
    chk(S_AWLEN, 0, "wr_word_awlen");
    wait_for(S_WR_RDY, 1, 20, "wr_word_done");
    tick();

    // Single half read
    exp_ar.push_back('{32'h0000_3002, 8'd0, 3'd1});
    exp_ret.push_back('{32'hD000_3002, 1'b1});
    rd_req = 1; rd_type = TYPE_HALF; rd_addr = 32'h0000_3002; r_gap = 0;
    tick(); rd_req = 0;
    wait_for(S_RET_LAST, 1, 20, "rd_half_last");
    tick();

    // Simultaneous write and read: write first, read waits through B
    exp_aw.push_back('{32'h0000_0100, 8'd0, 3'd2});
    exp_w.push_back('{32'h0BAD_F00D, 4'hf, 1'b1});
    exp_ar.push_back('{32'h0000_0200, 8'd3, 3'd2});
    exp_ret.push_back('{32'hD000_0200, 1'b0}); exp_ret.push_back('{32'hD100_0200, 1'b0});
    exp_ret.push_back('{32'hD200_0200, 1'b0}); exp_ret.push_back('{32'hD300_0200, 1'b1});
    wr_req = 1; wr_type = TYPE_WORD; wr_addr = 32'h0000_0100; wr_wstrb = 4'hf;
    wr_data = 128'h0BADF00D;
    rd_req = 1; rd_type = TYPE_LINE; rd_addr = 32'h0000_0208;
    chk(S_WR_RDY, 1, "both_wr_rdy"); chk(S_RD_RDY, 0, "both_rd_masked");
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1) wr_req = 0;
      chk(S_RD_RDY, 0, "both_rd_blocked"); chk(S_ARVALID, 0, "both_ar_blocked");
    end
    tick(); chk(S_RD_RDY, 1, "both_rd_rdy"); chk(S_ARVALID, 0, "both_ar_not_yet");
    tick(); rd_req = 0; chk(S_ARVALID, 1, "both_arvalid");
    wait_for(S_RET_LAST, 1, 20, "both_rd_last");
    tick();

    // Backpressure: every ready held low 5 cycles, slow B
    ar_stall = 5; aw_stall = 5; w_stall = 5; b_delay = 3;
    exp_aw.push_back('{32'h0000_6000, 8'd3, 3'd2});
    exp_w.push_back('{32'h0A0A_0A01, 4'hf, 1'b0}); exp_w.push_back('{32'h0B0B_0B02, 4'hf, 1'b0});
    exp_w.push_back('{32'h0C0C_0C03, 4'hf, 1'b0}); exp_w.push_back('{32'h0D0D_0D04, 4'hf, 1'b1});
    wr_req = 1; wr_type = TYPE_LINE; wr_addr = 32'h0000_6000;
    wr_data = 128'h0D0D0D04_0C0C0C03_0B0B0B02_0A0A0A01;
    tick(); wr_req = 0;
    tick(); tick(); chk(S_AWVALID, 1, "bp_awvalid_held");
    wait_for(S_WR_RDY, 1, 80, "bp_wr_done");
    exp_ar.push_back('{32'h0000_5550, 8'd3, 3'd2});
    exp_ret.push_back('{32'hD000_5550, 1'b0}); exp_ret.push_back('{32'hD100_5550, 1'b0});
    exp_ret.push_back('{32'hD200_5550, 1'b0}); exp_ret.push_back('{32'hD300_5550, 1'b1});
    rd_req = 1; rd_type = TYPE_LINE; rd_addr = 32'h0000_5554;
    tick(); rd_req = 0;
    tick(); tick(); chk(S_ARVALID, 1, "bp_arvalid_held");
    wait_for(S_RET_LAST, 1, 40, "bp_rd_last");
    tick();
    ar_stall = 0; aw_stall = 0; w_stall = 0; b_delay = 0;

    // Reset during second W beat: only beats 0 and 1 reach the slave
    exp_aw.push_back('{32'h0000_8000, 8'd3, 3'd2});
    exp_w.push_back('{32'h5555_0001, 4'hf, 1'b0}); exp_w.push_back('{32'h5555_0002, 4'hf, 1'b0});
    wr_req = 1; wr_type = TYPE_LINE; wr_addr = 32'h0000_8000;
    wr_data = 128'h55550004_55550003_55550002_55550001;
    tick(); wr_req = 0;
    tick(); tick(); resetn = 0;
    tick(); resetn = 1;
    chk(S_AWVALID, 0, "rst_mid_awvalid"); chk(S_WVALID, 0, "rst_mid_wvalid");
    chk(S_BREADY, 0, "rst_mid_bready");   chk(S_ARVALID, 0, "rst_mid_arvalid");
    chk(S_WR_RDY, 1, "rst_mid_wr_rdy");   chk(S_RD_RDY, 1, "rst_mid_rd_rdy");
    tick();
    exp_ar.push_back('{32'h0000_7770, 8'd3, 3'd2});
    exp_ret.push_back('{32'hD000_7770, 1'b0}); exp_ret.push_back('{32'hD100_7770, 1'b0});
    exp_ret.push_back('{32'hD200_7770, 1'b0}); exp_ret.push_back('{32'hD300_7770, 1'b1});
    rd_req = 1; rd_type = TYPE_LINE; rd_addr = 32'h0000_7778; r_gap = 1;
    tick(); rd_req = 0;
    wait_for(S_RET_LAST, 1, 20, "post_rst_rd_last");
    tick(); chk(S_RD_RDY, 1, "post_rst_rd_rdy");
    tick(); tick();
    done = 1;
  end

endmodule

// File: doc/cache_axi_adapter.md
# cache_axi_adapter

Converts one cache's native refill/writeback interface (rd_req/ret_* and wr_req/wr_rdy) into AXI4 read and write transactions. It sits directly downstream of the cache, replacing the behavioural memory responder used in cache bring-up, and upstream of the AXI interconnect or SRAM controller. It holds one outstanding read and one outstanding write. A write always drains before any read is accepted, which keeps refill data coherent with a preceding dirty-line writeback.

## Interface
- No parameters. Fixed values: AXI ID 0, burst INCR (2'b01), lock/cache/prot 0; tied at the top level and not ports here.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- rd_req  in  1  cache read request
- rd_type  in  3  3'b000/001/010 = byte/half/word single, 3'b100 = 16-byte line
- rd_addr  in  32  read address
- rd_rdy  out  1  read request accepted this cycle if rd_req=1
- ret_valid / ret_last  out  1/1  return beat valid / final beat
- ret_data  out  32  return beat data
- wr_req  in  1  cache write request
- wr_type  in  3  same encoding as rd_type
- wr_addr  in  32  write address
- wr_wstrb  in  4  byte strobe, single-word writes only
- wr_data  in  128  line data; bits [31:0] for single writes
- wr_rdy  out  1  write request accepted this cycle if wr_req=1
- araddr/arlen/arsize/arvalid  out  32/8/3/1; arready  in  1  — AR channel
- rdata/rresp/rlast/rvalid  in  32/2/1/1; rready  out  1  — R channel
- awaddr/awlen/awsize/awvalid  out  32/8/3/1; awready  in  1  — AW channel
- wdata/wstrb/wlast/wvalid  out  32/4/1/1; wready  in  1  — W channel
- bresp/bvalid  in  2/1; bready  out  1  — B channel

## Operation
**Read FSM: R_IDLE → R_AR → R_DATA → R_IDLE.**
- rd_rdy = (R_IDLE && W_IDLE && !wr_req).
- Request accept: on rd_req && rd_rdy, latch the address fields.
  - Line: araddr = {rd_addr[31:4],4'h0}, arlen = 3, arsize = 2.
  - Single: araddr = rd_addr, arlen = 0, arsize = rd_type[1:0].
- R_AR: arvalid = 1. On arready, go to R_DATA.
- R_DATA: rready = 1, ret_valid = rvalid, ret_data = rdata, ret_last = rlast.
  - The cache cannot stall, so rready stays 1 throughout R_DATA.
  - On rvalid && rlast, return to R_IDLE.

**Write FSM: W_IDLE → W_AW → W_DATA → W_B → W_IDLE.**
- wr_rdy = W_IDLE.
- Request accept: latch addr, type, strobe and all 128 data bits.
  - Line: awaddr line-aligned, awlen = 3, awsize = 2, wstrb = 4'hf, 4 beats with words [31:0] first.
  - Single: awaddr = wr_addr, awlen = 0, awsize = wr_type[1:0], wstrb = wr_wstrb, 1 beat.
- W_AW: awvalid = 1. On awready, go to W_DATA.
- W_DATA: wvalid = 1, wlast on the final beat, beat counter advances on wready. After the last beat handshake, go to W_B.
- W_B: bready = 1. On bvalid, return to W_IDLE.

**Errors:** non-OKAY rresp/bresp values are ignored and data is passed through unchanged.

**Same-cycle rd_req and wr_req:** the write is accepted and the read waits, because rd_rdy is masked by wr_req.

## Timing
**Reset values:**
- All FSMs idle; all AXI valid/ready outputs 0; ret_valid = 0.
- Address and length registers 0.
- rd_rdy = 1 and wr_rdy = 1 in the first cycle after reset.

**Output timing:**
- AXI address outputs are registered.
- ret_* are combinational from the R channel: no added latency.

**Latency:**
- Read accepted at T: arvalid at T+1; the first ret_valid appears in the same cycle as the first rvalid.
- Write accepted at T: awvalid at T+1; first wvalid in the cycle after the AW handshake; wr_rdy = 1 in the cycle after the B handshake.

**Handshake rules:**
- Each valid holds its value and its payload stable until the matching ready.
- A zero-wait slave gives a 4-beat line write of 7 cycles from accept to wr_rdy.

**Reset mid-transaction:** abandons the operation immediately and all valids drop. The slave shares resetn, so this is legal.

## Structure
- Package cache_axi_pkg holds:
  - rd/wr type encodings (TYPE_BYTE, TYPE_HALF, TYPE_WORD, TYPE_LINE)
  - read and write state encodings
  - AXI constants: BURST_INCR, RESP_OKAY, fixed ID/cache/prot values
- Sub-module wr_beat_serializer: takes the 128-bit line, the beat count and wready; produces wdata/wlast. It holds the 2-bit beat counter and the shift logic.

## Test plan
- Line read, rd_addr=32'h1234_5678, slave arready=1 with 2-cycle gap before R: araddr=32'h1234_5670, arlen=3, arsize=2; 4 ret_valid beats matching rdata; ret_last only on beat 4; rd_rdy returns to 1 in the following cycle.
- Line write, wr_data=128'h4444…_3333…_2222…_1111…: awlen=3; wdata beats 1111…, 2222…, 3333…, 4444… in order; wstrb=4'hf; wlast on beat 4; wr_rdy=0 until after bvalid.
- Single word write, wr_wstrb=4'b0111, wr_type=3'b010: awlen=0, awsize=2, wstrb=4'b0111, wlast on the only beat.
- Simultaneous wr_req + rd_req from idle: write accepted, rd_rdy=0 through the B handshake; arvalid rises only after the write completes.
- Backpressure: awready/wready/arready held 0 for 5 cycles: valids stay 1 and payloads are unchanged, with no beat lost or duplicated.
- resetn=0 during W_DATA beat 2: the next cycle shows all valids 0 and wr_rdy=rd_rdy=1. A fresh line read then completes correctly.
